// File: rtl/dadder_bcd_core.sv
// Two-stage BCD adder/subtractor. Stage 1 resolves the low half of the
// digits plus the carry into the high half; stage 2 (the output register)
// resolves the high half. A stalled output freezes both stages.
module dadder_bcd_core #(
    parameter int NUM_DIGITS = 4,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    cp_en_i,
    input  logic                    cp_sub_i,
    input  logic                    cp_flush_i,
    output logic                    cp_busy_o,
    output logic [ERR_CNT_W-1:0]    cp_err_count_o,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [4*NUM_DIGITS-1:0] in_a_i,
    input  logic [4*NUM_DIGITS-1:0] in_b_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [4*NUM_DIGITS-1:0] out_sum_o,
    output logic                    out_cout_o,
    output logic                    out_err_o
);

    localparam int H  = NUM_DIGITS / 2;
    localparam int W  = 4 * NUM_DIGITS;
    localparam int HW = 4 * H;

    // One decimal digit: {carry, digit}. Subtraction uses the nine's
    // complement of b; the +1 comes in as the initial carry.
    function automatic logic [4:0] bcd_digit(input logic [3:0] a, input logic [3:0] b,
                                             input logic sub, input logic c);
        logic [3:0] bb;
        logic [4:0] t;
        bb = sub ? (4'd9 - b) : b;
        t  = {1'b0, a} + {1'b0, bb} + {4'b0000, c};
        if (t > 5'd9) bcd_digit = {1'b1, t[3:0] + 4'd6};
        else          bcd_digit = {1'b0, t[3:0]};
    endfunction

    function automatic logic has_illegal(input logic [W-1:0] x);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (x[4*i +: 4] > 4'd9) bad = 1'b1;
        return bad;
    endfunction

    logic          s1_vld_q;
    logic [HW-1:0] s1_lo_q;
    logic          s1_c_q;
    logic [HW-1:0] s1_ahi_q;
    logic [HW-1:0] s1_bhi_q;
    logic          s1_sub_q;
    logic          s1_err_q;

    logic          out_vld_q;
    logic [W-1:0]  out_sum_q;
    logic          out_cout_q;
    logic          out_err_q;
    logic [ERR_CNT_W-1:0] err_cnt_q;

    logic          stall;
    logic          accept;
    logic          in_err;
    logic [HW-1:0] s1_lo_d;
    logic          s1_c_d;
    logic [W-1:0]  out_sum_d;
    logic          out_cout_d;

    assign stall      = out_vld_q && !out_ready_i;
    assign in_ready_o = !reset_i && cp_en_i && !stall && !cp_flush_i;
    assign accept     = in_valid_i && in_ready_o;
    assign in_err     = has_illegal(in_a_i) || has_illegal(in_b_i);

    // Low-half digit chain straight off the input operands.
    always_comb begin
        logic       c;
        logic [4:0] r;
        c       = cp_sub_i;
        s1_lo_d = '0;
        for (int i = 0; i < H; i++) begin
            r = bcd_digit(in_a_i[4*i +: 4], in_b_i[4*i +: 4], cp_sub_i, c);
            s1_lo_d[4*i +: 4] = r[3:0];
            c = r[4];
        end
        s1_c_d = c;
    end

    // High-half digit chain; an illegal-digit transaction yields zero result.
    always_comb begin
        logic          c;
        logic [4:0]    r;
        logic [HW-1:0] hi;
        c  = s1_c_q;
        hi = '0;
        for (int i = 0; i < H; i++) begin
            r = bcd_digit(s1_ahi_q[4*i +: 4], s1_bhi_q[4*i +: 4], s1_sub_q, c);
            hi[4*i +: 4] = r[3:0];
            c = r[4];
        end
        out_sum_d  = s1_err_q ? '0 : {hi, s1_lo_q};
        out_cout_d = s1_err_q ? 1'b0 : c;
    end

    // Stage 1 register; flush empties it even while stalled.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            s1_vld_q <= 1'b0;
            s1_lo_q  <= '0;
            s1_c_q   <= 1'b0;
            s1_ahi_q <= '0;
            s1_bhi_q <= '0;
            s1_sub_q <= 1'b0;
            s1_err_q <= 1'b0;
        end else if (cp_flush_i) begin
            s1_vld_q <= 1'b0;
        end else if (!stall) begin
            s1_vld_q <= accept;
            if (accept) begin
                s1_lo_q  <= s1_lo_d;
                s1_c_q   <= s1_c_d;
                s1_ahi_q <= in_a_i[W-1:HW];
                s1_bhi_q <= in_b_i[W-1:HW];
                s1_sub_q <= cp_sub_i;
                s1_err_q <= in_err;
            end
        end
    end

    // Output register; payload only loads when stage 1 carries a transaction.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            out_vld_q  <= 1'b0;
            out_sum_q  <= '0;
            out_cout_q <= 1'b0;
            out_err_q  <= 1'b0;
        end else if (cp_flush_i) begin
            out_vld_q <= 1'b0;
        end else if (!stall) begin
            out_vld_q <= s1_vld_q;
            if (s1_vld_q) begin
                out_sum_q  <= out_sum_d;
                out_cout_q <= out_cout_d;
                out_err_q  <= s1_err_q;
            end
        end
    end

    // Saturating count of accepted transactions carrying an illegal digit.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)
            err_cnt_q <= '0;
        else if (accept && in_err && (err_cnt_q != {ERR_CNT_W{1'b1}}))
            err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
    end

    assign out_valid_o    = out_vld_q;
    assign out_sum_o      = out_sum_q;
    assign out_cout_o     = out_cout_q;
    assign out_err_o      = out_err_q;
    assign cp_busy_o      = s1_vld_q || out_vld_q;
    assign cp_err_count_o = err_cnt_q;

endmodule

// File: tb/tb_dadder_bcd_core.sv
// Directed bench for dadder_bcd_core (NUM_DIGITS=4): arithmetic vectors,
// illegal digits and counter saturation, backpressure, flush, cp_en, reset.
module tb_dadder_bcd_core;

    logic        clk = 1'b0;
    logic        reset;
    logic        cp_en, cp_sub, cp_flush;
    logic        cp_busy;
    logic [7:0]  cp_err_count;
    logic        in_valid, in_ready;
    logic [15:0] in_a, in_b;
    logic        out_valid, out_ready;
    logic [15:0] out_sum;
    logic        out_cout, out_err;

    int total = 0;
    int bad   = 0;

    dadder_bcd_core #(.NUM_DIGITS(4), .ERR_CNT_W(8)) dut (
        .clk_i(clk), .reset_i(reset),
        .cp_en_i(cp_en), .cp_sub_i(cp_sub), .cp_flush_i(cp_flush),
        .cp_busy_o(cp_busy), .cp_err_count_o(cp_err_count),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_a_i(in_a), .in_b_i(in_b),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_sum_o(out_sum), .out_cout_o(out_cout), .out_err_o(out_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single transaction with out_ready=1; checks the two-cycle latency.
    task automatic run1(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic sub, input logic [15:0] es, input logic ec, input logic ee);
        in_valid = 1'b1; in_a = a; in_b = b; cp_sub = sub; out_ready = 1'b1;
        #1;
        chk({tag, ".in_ready"}, in_ready, 1);
        tick();
        in_valid = 1'b0; in_a = 16'hFFFF; in_b = 16'hFFFF; cp_sub = ~sub;
        chk({tag, ".lat1_valid"}, out_valid, 0);
        chk({tag, ".busy"}, cp_busy, 1);
        tick();
        chk({tag, ".valid"}, out_valid, 1);
        chk({tag, ".sum"}, out_sum, es);
        chk({tag, ".cout"}, out_cout, ec);
        chk({tag, ".err"}, out_err, ee);
        tick();
        chk({tag, ".drained"}, out_valid, 0);
    endtask

    logic [15:0] bp_a   [4] = '{16'h0001, 16'h0010, 16'h0999, 16'h5000};
    logic [15:0] bp_b   [4] = '{16'h0002, 16'h0020, 16'h0001, 16'h5000};
    logic [15:0] bp_s   [4] = '{16'h0003, 16'h0030, 16'h1000, 16'h0000};
    logic        bp_c   [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        reset = 1'b1; cp_en = 1'b1; cp_sub = 1'b0; cp_flush = 1'b0;
        in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
        #12;
        chk("rst.in_ready", in_ready, 0);
        chk("rst.out_valid", out_valid, 0);
        chk("rst.out_sum", out_sum, 0);
        chk("rst.out_cout", out_cout, 0);
        chk("rst.out_err", out_err, 0);
        chk("rst.busy", cp_busy, 0);
        chk("rst.err_count", cp_err_count, 0);
        tick();
        reset = 1'b0;
        tick();

        run1("add1234", 16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0);
        run1("add9999", 16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        run1("sub5m7",  16'h0005, 16'h0007, 1'b1, 16'h9998, 1'b0, 1'b0);
        run1("sub100m1",16'h0100, 16'h0001, 1'b1, 16'h0099, 1'b1, 1'b0);
        chk("cnt0", cp_err_count, 0);
        run1("errA",    16'h00A0, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b1);
        chk("cnt1", cp_err_count, 1);
        run1("errBhi",  16'h0001, 16'hA000, 1'b1, 16'h0000, 1'b0, 1'b1);
        chk("cnt2", cp_err_count, 2);

        // cp_en falls after one accept: that item completes, nothing else enters.
        cp_en = 1'b1; in_valid = 1'b1; in_a = 16'h0042; in_b = 16'h0013; cp_sub = 1'b0;
        tick();
        cp_en = 1'b0; in_a = 16'h1111; in_b = 16'h1111;
        #1;
        chk("en.in_ready", in_ready, 0);
        tick();
        chk("en.valid", out_valid, 1);
        chk("en.sum", out_sum, 16'h0055);
        tick();
        chk("en.valid_after", out_valid, 0);
        chk("en.busy_after", cp_busy, 0);
        in_valid = 1'b0; cp_en = 1'b1;

        // Back-to-back 4 with a 5-cycle stall on the first result.
        begin
            int sent = 0, rcv = 0, hold = 0;
            bit seen = 0;
            out_ready = 1'b0; cp_sub = 1'b0;
            for (int cyc = 0; cyc < 40 && rcv < 4; cyc++) begin
                if (sent < 4) begin
                    in_valid = 1'b1; in_a = bp_a[sent]; in_b = bp_b[sent];
                end else begin
                    in_valid = 1'b0;
                end
                if (out_valid && !seen) seen = 1;
                out_ready = seen && (hold >= 5);
                #1;
                if (out_valid && !out_ready) begin
                    chk("bp.stall_in_ready", in_ready, 0);
                    chk("bp.stall_hold_sum", out_sum, bp_s[rcv]);
                    hold++;
                end
                if (in_valid && in_ready) sent++;
                if (out_valid && out_ready) begin
                    chk("bp.sum", out_sum, bp_s[rcv]);
                    chk("bp.cout", out_cout, bp_c[rcv]);
                    rcv++;
                end
                tick();
            end
            in_valid = 1'b0;
            chk("bp.count", rcv, 4);
            chk("bp.stall_len", hold, 5);
            tick();
            chk("bp.no_dup", out_valid, 0);
        end

        // Flush with both stages full and the output stalled.
        out_ready = 1'b0;
        in_valid = 1'b1; in_a = 16'h0011; in_b = 16'h0022;
        tick();
        in_a = 16'h0033; in_b = 16'h0044;
        tick();
        in_valid = 1'b0;
        chk("fl.pre_valid", out_valid, 1);
        chk("fl.pre_busy", cp_busy, 1);
        cp_flush = 1'b1; in_valid = 1'b1; in_a = 16'h0077;
        #1;
        chk("fl.in_ready", in_ready, 0);
        tick();
        cp_flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        chk("fl.valid", out_valid, 0);
        chk("fl.busy", cp_busy, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("fl.quiet", out_valid, 0);
        end
        chk("fl.cnt", cp_err_count, 2);
        run1("fl.next", 16'h0002, 16'h0003, 1'b0, 16'h0005, 1'b0, 1'b0);

        // 300 illegal transactions saturate the counter.
        out_ready = 1'b1; in_valid = 1'b1; in_a = 16'h00A0; in_b = 16'h0001;
        for (int i = 0; i < 300; i++) tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("sat.cnt", cp_err_count, 8'hFF);

        // Async reset with both stages valid.
        out_ready = 1'b0; in_valid = 1'b1; in_a = 16'h0123; in_b = 16'h0456;
        tick();
        in_a = 16'h0321;
        tick();
        in_valid = 1'b0;
        chk("ar.pre_busy", cp_busy, 1);
        #2 reset = 1'b1;
        #1;
        chk("ar.valid", out_valid, 0);
        chk("ar.sum", out_sum, 0);
        chk("ar.busy", cp_busy, 0);
        chk("ar.cnt", cp_err_count, 0);
        chk("ar.in_ready", in_ready, 0);
        tick();
        reset = 1'b0;
        tick();
        chk("ar.post_valid", out_valid, 0);
        run1("ar.first", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
